// File: rtl/smarthome_pkg.sv
// rtl/smarthome_pkg.sv - shared FSM state encodings and key codes for the keypad front end
package smarthome_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_GRANTED = 3'd3,
    ST_LOCKED  = 3'd4
  } auth_state_e;

  localparam logic [3:0] KEY_CLEAR     = 4'hF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser, level debounce and rising-edge pulse for one raw button
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             prev_q, prev_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    lvl_d   = lvl_q;
    cnt_d   = '0;
    prev_d  = lvl_q;
    pulse_d = lvl_q & ~prev_q;
    // Any sample equal to the accepted level restarts the run of differing samples.
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        lvl_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/keypad_auth_front.sv
// rtl/keypad_auth_front.sv - debounced on/off buttons plus passcode entry, check and lockout FSM
module keypad_auth_front
  import smarthome_pkg::*;
#(
  parameter int CODE_LEN     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int MAX_FAIL     = 3,
  parameter int LOCK_CYC     = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  on_btn_raw,
  input  logic                  off_btn_raw,
  input  logic                  digit_valid,
  input  logic [3:0]            digit,
  input  logic [4*CODE_LEN-1:0] code_set,
  output logic                  onClick,
  output logic                  offClick,
  output logic                  keypad,
  output logic                  pass_repeat,
  output logic                  locked,
  output logic [2:0]            digit_cnt
);

  localparam int CODE_W  = 4 * CODE_LEN;
  localparam int TMR_MAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam logic [2:0] CODE_LEN_C = 3'(CODE_LEN);

  logic on_pulse, off_pulse;
  logic on_click, off_click;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_on_db (
    .clk    (clk),
    .rst_n  (reset),
    .btn_raw(on_btn_raw),
    .pulse  (on_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_off_db (
    .clk    (clk),
    .rst_n  (reset),
    .btn_raw(off_btn_raw),
    .pulse  (off_pulse)
  );

  // Off has priority so a simultaneous press can never re-arm the session.
  assign on_click  = on_pulse & ~off_pulse;
  assign off_click = off_pulse;

  auth_state_e        state_q, state_d;
  logic [CODE_W-1:0]  buf_q, buf_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic               rep_q, rep_d;
  logic               keypad_q, keypad_d;
  logic               locked_q, locked_d;

  logic               digit_ok;
  logic               clear_ok;
  logic [FAIL_W-1:0]  fail_inc;

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    fail_d   = fail_q;
    rep_d    = 1'b0;
    digit_ok = digit_valid && is_digit(digit);
    clear_ok = digit_valid && (digit == KEY_CLEAR);
    fail_inc = fail_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (digit_ok) begin
          buf_d   = CODE_W'(digit);
          cnt_d   = 3'd1;
          state_d = (CODE_LEN == 1) ? ST_CHECK : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (digit_ok) begin
          buf_d = (buf_q << 4) | CODE_W'(digit);
          cnt_d = cnt_q + 3'd1;
          tmr_d = '0;
          if (cnt_q + 3'd1 == CODE_LEN_C) begin
            state_d = ST_CHECK;
          end
        end else if (clear_ok) begin
          buf_d = '0;
          cnt_d = '0;
          tmr_d = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (buf_q == code_set) begin
          fail_d  = '0;
          state_d = ST_GRANTED;
        end else begin
          rep_d   = 1'b1;
          fail_d  = fail_inc;
          state_d = (fail_inc >= FAIL_W'(MAX_FAIL)) ? ST_LOCKED : ST_IDLE;
        end
      end

      ST_GRANTED: begin
        cnt_d = '0;
        if (off_click) begin
          state_d = ST_IDLE;
        end
      end

      ST_LOCKED: begin
        cnt_d = '0;
        if (tmr_q == TMR_W'(LOCK_CYC - 1)) begin
          tmr_d   = '0;
          fail_d  = '0;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: begin
        buf_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    keypad_d = (state_d == ST_GRANTED);
    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      fail_q   <= '0;
      rep_q    <= 1'b0;
      keypad_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      fail_q   <= fail_d;
      rep_q    <= rep_d;
      keypad_q <= keypad_d;
      locked_q <= locked_d;
    end
  end

  assign onClick     = on_click;
  assign offClick    = off_click;
  assign keypad      = keypad_q;
  assign pass_repeat = rep_q;
  assign locked      = locked_q;
  assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_keypad_auth_front.sv
// tb/tb_keypad_auth_front.sv - self-checking bench for keypad_auth_front
module tb_keypad_auth_front;

  localparam int MAX_FAIL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        on_btn_raw, off_btn_raw, digit_valid;
  logic [3:0]  digit;
  logic [15:0] code_set;
  logic        onClick, offClick, keypad, pass_repeat, locked;
  logic [2:0]  digit_cnt;

  int nchk = 0, nerr = 0;
  int cyc = 0, n_on = 0, n_off = 0, n_rep = 0, n_lock = 0, on_cyc = -1;
  int m_fail = 0;

  keypad_auth_front dut (
    .clk        (clk),
    .reset      (reset),
    .on_btn_raw (on_btn_raw),
    .off_btn_raw(off_btn_raw),
    .digit_valid(digit_valid),
    .digit      (digit),
    .code_set   (code_set),
    .onClick    (onClick),
    .offClick   (offClick),
    .keypad     (keypad),
    .pass_repeat(pass_repeat),
    .locked     (locked),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (onClick) begin n_on++; on_cyc = cyc; end
    if (offClick) n_off++;
    if (pass_repeat) n_rep++;
    if (locked) n_lock++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    digit       = 4'h0;
  endtask

  task automatic enter(input logic [15:0] val, input int max_gap, input bit check_cnt);
    logic [3:0] nib;
    for (int i = 3; i >= 0; i--) begin
      nib = val[i*4 +: 4];
      press(nib);
      if (check_cnt) chk("collect_cnt", digit_cnt, 4 - i);
      if (i != 0) repeat ($urandom_range(max_gap, 0)) tick();
    end
  endtask

  task automatic off_exit();
    bit seen;
    seen = 1'b0;
    off_btn_raw = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (offClick) seen = 1'b1;
    end
    chk("off_click_seen", seen, 1);
    chk("keypad_before_off", keypad, 1);
    tick();
    chk("keypad_after_off", keypad, 0);
    off_btn_raw = 1'b0;
    repeat (25) tick();
  endtask

  // Entry of one four-digit attempt; the outcome comes from comparing digits, not from DUT state.
  task automatic attempt(input logic [15:0] val, input int max_gap);
    bit good;
    good = (val == code_set);
    enter(val, max_gap, 1'b1);
    chk("check_state_cnt", digit_cnt, 4);
    chk("keypad_in_check", keypad, 0);
    tick();
    chk("cnt_after_check", digit_cnt, 0);
    if (good) begin
      m_fail = 0;
      chk("grant_keypad", keypad, 1);
      chk("grant_no_repeat", pass_repeat, 0);
      off_exit();
    end else begin
      m_fail++;
      chk("reject_repeat", pass_repeat, 1);
      chk("reject_keypad", keypad, 0);
      chk("reject_locked", locked, (m_fail >= MAX_FAIL) ? 1 : 0);
      tick();
      chk("repeat_one_cycle", pass_repeat, 0);
    end
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v = (v << 4) | 16'($urandom_range(9, 0));
    return v;
  endfunction

  initial begin
    int n0, r0, stable_cyc, lock_wait;
    logic [15:0] v;
    logic [3:0]  last;

    reset = 1'b0; on_btn_raw = 1'b0; off_btn_raw = 1'b0;
    digit_valid = 1'b0; digit = 4'h0; code_set = 16'h1234;
    #1;
    chk("reset_outputs", {onClick, offClick, keypad, pass_repeat, locked, digit_cnt}, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Correct code: keypad rises two cycles after the 4th strobe.
    enter(16'h1234, 0, 1'b1);
    chk("cnt_at_check", digit_cnt, 4);
    chk("keypad_1_after", keypad, 0);
    tick();
    chk("keypad_2_after", keypad, 1);
    press(4'h5);
    chk("granted_ignores_digit", digit_cnt, 0);
    chk("granted_hold", keypad, 1);
    off_exit();

    // Bouncy on button: one pulse, 18 cycles after the level settles.
    n0 = n_on;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) on_btn_raw = ~on_btn_raw;
      tick();
    end
    on_btn_raw = 1'b1;
    stable_cyc = cyc + 1;
    repeat (40) tick();
    chk("bounce_pulse_count", n_on - n0, 1);
    chk("bounce_latency", on_cyc - stable_cyc, 18);
    on_btn_raw = 1'b0;
    repeat (30) tick();
    chk("release_no_pulse", n_on - n0, 1);

    // Simultaneous presses: only off reports.
    n0 = n_on; r0 = n_off;
    on_btn_raw = 1'b1; off_btn_raw = 1'b1;
    repeat (25) tick();
    chk("both_on_suppressed", n_on - n0, 0);
    chk("both_off_pulse", n_off - r0, 1);
    on_btn_raw = 1'b0; off_btn_raw = 1'b0;
    repeat (25) tick();

    // Timeout abandons a partial entry without counting a failure.
    r0 = n_rep;
    press(4'h1);
    press(4'h2);
    chk("timeout_cnt_start", digit_cnt, 2);
    repeat (999) tick();
    chk("timeout_edge_minus1", digit_cnt, 2);
    tick();
    chk("timeout_cleared", digit_cnt, 0);
    chk("timeout_no_repeat", n_rep - r0, 0);
    attempt(16'h1234, 3);

    // Clear key and ignored A-E keys.
    press(4'h1);
    press(4'hA + 4'($urandom_range(4, 0)));
    chk("ignored_key_cnt", digit_cnt, 1);
    press(4'h2);
    press(4'hF);
    chk("clear_cnt", digit_cnt, 0);
    attempt(16'h1234, 2);

    // Randomized codes and attempts against the model, never reaching lockout.
    for (int r = 0; r < 6; r++) begin
      code_set = rand_code();
      if (m_fail == MAX_FAIL - 1 || $urandom_range(1, 0) == 1) begin
        v = code_set;
      end else begin
        v = rand_code();
        if (v == code_set) begin
          last = v[3:0];
          v[3:0] = (last == 4'd9) ? 4'd0 : last + 4'd1;
        end
      end
      attempt(v, 5);
    end
    code_set = 16'h1234;
    attempt(16'h1234, 1);

    // Three wrong codes lock the keypad for exactly the lockout period.
    r0 = n_rep; n_lock = 0;
    for (int k = 0; k < MAX_FAIL; k++) attempt(16'h1235, 2);
    chk("lock_repeat_count", n_rep - r0, 3);
    chk("locked_level", locked, 1);
    enter(16'h1234, 1, 1'b0);
    chk("locked_ignores_digits", digit_cnt, 0);
    tick(); tick();
    chk("locked_no_grant", keypad, 0);
    n0 = n_on;
    on_btn_raw = 1'b1;
    repeat (25) tick();
    on_btn_raw = 1'b0;
    repeat (25) tick();
    chk("locked_button_pulse", n_on - n0, 1);
    lock_wait = 0;
    while (locked && lock_wait < 6000) begin
      tick();
      lock_wait++;
    end
    chk("lock_released", locked, 0);
    tick();
    chk("lock_duration", n_lock, 5000);
    m_fail = 0;
    attempt(16'h1234, 2);

    // Reset mid-entry with the on button held through it.
    r0 = n_rep;
    press(4'h1); press(4'h2); press(4'h3);
    chk("pre_reset_cnt", digit_cnt, 3);
    on_btn_raw = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("reset_mid_entry", {onClick, offClick, keypad, pass_repeat, locked, digit_cnt}, 0);
    tick(); tick();
    n0 = n_on;
    reset = 1'b1;
    repeat (25) tick();
    chk("held_through_reset_pulse", n_on - n0, 1);
    chk("reset_no_repeat", n_rep - r0, 0);
    on_btn_raw = 1'b0;
    repeat (25) tick();
    m_fail = 0;
    attempt(16'h1234, 2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/keypad_auth_front.md
KEYPAD_AUTH_FRONT -- requirements
Module: keypad_auth_front

Interface
REQ-001 Parameter CODE_LEN, default 4: number of digits in one passcode.
REQ-002 Parameter DEBOUNCE_CYC, default 16: cycles a synchronised button level must hold before it is accepted.
REQ-003 Parameter TIMEOUT_CYC, default 1000: idle cycles allowed between digits before entry is abandoned.
REQ-004 Parameter MAX_FAIL, default 3: consecutive wrong codes that trigger lockout.
REQ-005 Parameter LOCK_CYC, default 5000: lockout duration in cycles.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset; 0 resets the block.
REQ-008 on_btn_raw  in  1  raw, bouncy "turn on" button, asynchronous to clk.
REQ-009 off_btn_raw  in  1  raw, bouncy "turn off" button, asynchronous to clk.
REQ-010 digit_valid  in  1  one-cycle strobe, synchronous to clk, qualifying digit.
REQ-011 digit  in  4  key code: 0-9 are digits, F is clear, A-E are ignored.
REQ-012 code_set  in  4*CODE_LEN  stored passcode, most-significant nibble is the first digit; static during use.
REQ-013 onClick  out  1  one-cycle pulse on an accepted press of the on button.
REQ-014 offClick  out  1  one-cycle pulse on an accepted press of the off button.
REQ-015 keypad  out  1  level; 1 while an authenticated session is active.
REQ-016 pass_repeat  out  1  one-cycle pulse when a wrong code is rejected.
REQ-017 locked  out  1  level; 1 during lockout.
REQ-018 digit_cnt  out  3  number of digits collected so far.

Function
REQ-019 Each raw button SHALL pass through a 2-flop synchroniser, then a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYC consecutive equal synchronised samples that differ from it.
REQ-020 onClick/offClick SHALL pulse one cycle after a debounced 0->1 edge; a held button SHALL produce no further pulse.
REQ-021 If both debounced edges occur in the same cycle, offClick SHALL pulse and onClick SHALL be suppressed.
REQ-022 Button pulses SHALL be generated in every FSM state, including LOCKED.
REQ-023 The FSM SHALL have five states: IDLE, COLLECT, CHECK, GRANTED and LOCKED.
REQ-024 IDLE: a digit 0-9 with digit_valid SHALL be stored and the FSM SHALL move to COLLECT with digit_cnt=1.
REQ-025 COLLECT: each digit 0-9 SHALL be shifted in and increment digit_cnt; when the CODE_LEN-th digit is taken, the FSM SHALL go to CHECK on the next cycle.
REQ-026 COLLECT: digit F SHALL clear the buffer, set digit_cnt=0 and keep the FSM in COLLECT; digits A-E SHALL be ignored without restarting the timeout.
REQ-027 COLLECT: TIMEOUT_CYC cycles with no accepted digit SHALL clear the buffer and return the FSM to IDLE, with no fail increment.
REQ-028 CHECK (one cycle) on a match: the fail counter SHALL be cleared and the FSM SHALL go to GRANTED; keypad SHALL rise the following cycle.
REQ-029 CHECK on a mismatch: pass_repeat SHALL pulse, the fail counter SHALL increment and the FSM SHALL go to IDLE; if the count reaches MAX_FAIL, the FSM SHALL go to LOCKED instead.
REQ-030 GRANTED: keypad SHALL be held at 1, digits SHALL be ignored, and an offClick pulse SHALL return the FSM to IDLE, with keypad at 0 the next cycle.
REQ-031 LOCKED: locked=1, digits SHALL be ignored; after LOCK_CYC cycles the FSM SHALL go to IDLE and the fail counter SHALL clear.
REQ-032 digit_cnt SHALL read 0 in IDLE, GRANTED and LOCKED, and SHALL never exceed CODE_LEN.

Reset
REQ-033 reset=0 SHALL immediately force: FSM=IDLE, all counters and the buffer to 0, debounced levels to 0, and all outputs to 0.
REQ-034 Reset asserted mid-entry, mid-session or mid-lockout SHALL discard all progress, with no pulses emitted on release.
REQ-035 A button held through reset release SHALL produce a pulse once it has debounced.

Structure
REQ-036 FSM state encodings and the digit constants (clear key = F) SHALL live in shared package smarthome_pkg.
REQ-037 Debouncing SHALL be a sub-module btn_debounce (synchroniser, counter and edge pulse), instantiated twice.

Verification
REQ-038 With code_set=16'h1234, enter 1,2,3,4: keypad SHALL be 1 from 2 cycles after the 4th strobe.
REQ-039 Enter 1,2,3,5 three times: pass_repeat SHALL pulse 3 times, locked SHALL be 1 for exactly 5000 cycles, and 1,2,3,4 entered during lockout SHALL be ignored.
REQ-040 on_btn_raw toggling every 3 cycles for 40 cycles, then held high: exactly one onClick pulse, 18 cycles after it goes stable.
REQ-041 Enter 1,2 and wait 1000 cycles: FSM SHALL be in IDLE with digit_cnt=0 and no pass_repeat; then 1,2,3,4 SHALL grant access.
REQ-042 Enter 1,2,F,1,2,3,4: access SHALL be granted; an offClick in GRANTED SHALL drop keypad the next cycle.
REQ-043 Assert reset after 3 digits: all outputs SHALL be 0 at once, and after release 1,2,3,4 SHALL grant access.
